// File: rtl/frame_sequencer.sv
// frame_sequencer: runs input-latch, physics and sprite-commit clients in order during vblank, then pulses swap.
module frame_sequencer #(
    parameter int V_ACTIVE = 480,
    parameter int TIMEOUT  = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] row,
    input  logic       enable,
    input  logic       clr_fault,
    input  logic [2:0] done,
    output logic [2:0] start,
    output logic       busy,
    output logic       swap,
    output logic [7:0] frame_cnt,
    output logic       overrun,
    output logic [2:0] timeout_fault
);
    typedef enum logic [2:0] {IDLE, WAIT0, WAIT1, WAIT2, SWAP} state_t;
    state_t state, state_d;
    logic vb, vb_q, vb_rise, vb_fall;
    logic waiting, got, tmo, ovr_set;
    logic [1:0] idx;
    logic [2:0] to_set, start_d;
    logic [15:0] cnt, cnt_d;
    assign vb      = row >= 10'(V_ACTIVE);
    assign vb_rise = vb & ~vb_q;
    assign vb_fall = ~vb & vb_q;
    assign waiting = state == WAIT0 || state == WAIT1 || state == WAIT2;
    assign idx     = state == WAIT2 ? 2'd2 : state == WAIT1 ? 2'd1 : 2'd0;
    // done is ignored in the cycle the start pulse is still on the port
    assign got     = waiting && done[idx] && !start[idx];
    assign tmo     = waiting && !got && cnt == 16'(TIMEOUT - 1);
    always_comb begin
        state_d = state;
        ovr_set = 1'b0;
        to_set  = 3'b000;
        if (state == IDLE) begin
            state_d = (vb_rise && enable) ? WAIT0 : IDLE;
        end else if (vb_fall) begin
            state_d = IDLE;
            ovr_set = 1'b1;
        end else if (state == SWAP) begin
            state_d = IDLE;
        end else if (got || tmo) begin
            state_d     = state_t'(state + 3'd1);
            to_set[idx] = tmo;
        end
        cnt_d   = (waiting && state_d == state) ? cnt + 16'd1 : 16'd0;
        start_d = state_d == state ? 3'b000 :
                  state_d == WAIT0 ? 3'b001 :
                  state_d == WAIT1 ? 3'b010 :
                  state_d == WAIT2 ? 3'b100 : 3'b000;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            vb_q          <= 1'b1;
            cnt           <= 16'd0;
            start         <= 3'b000;
            busy          <= 1'b0;
            swap          <= 1'b0;
            frame_cnt     <= 8'd0;
            overrun       <= 1'b0;
            timeout_fault <= 3'b000;
        end else begin
            state         <= state_d;
            vb_q          <= vb;
            cnt           <= cnt_d;
            start         <= start_d;
            busy          <= state_d != IDLE;
            swap          <= state_d == SWAP;
            frame_cnt     <= frame_cnt + 8'(state_d == SWAP);
            overrun       <= ovr_set | (overrun & ~clr_fault);
            timeout_fault <= to_set | (timeout_fault & ~{3{clr_fault}});
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed checks of sequencing, timeout, overrun, gating, reset and wrap.
module tb_frame_sequencer;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, clr_fault = 1'b0;
    logic [9:0] row = 10'd0;
    logic [2:0] done = 3'b000;
    logic [2:0] start, timeout_fault;
    logic busy, swap, overrun;
    logic [7:0] frame_cnt;
    int vectors = 0, miscompares = 0;

    frame_sequencer #(.V_ACTIVE(480), .TIMEOUT(20)) dut (
        .clk(clk), .rst(rst), .row(row), .enable(enable), .clr_fault(clr_fault),
        .done(done), .start(start), .busy(busy), .swap(swap), .frame_cnt(frame_cnt),
        .overrun(overrun), .timeout_fault(timeout_fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_start"}, 8'(start), 8'h0);
        chk({tag, "_busy"}, 8'(busy), 8'h0);
        chk({tag, "_swap"}, 8'(swap), 8'h0);
    endtask

    // wait dly cycles after the start pulse, then pulse done[k] for one cycle
    task automatic serve(input int k, input int dly);
        repeat (dly) begin
            tick();
            chk("wait_start", 8'(start), 8'h0);
            chk("wait_busy", 8'(busy), 8'h1);
        end
        done = 3'(1 << k);
        tick();
        done = 3'b000;
    endtask

    task automatic vb_enter();
        row = 10'd0;
        tick();
        row = 10'd480;
        tick();
    endtask

    task automatic clean_frame();
        vb_enter();
        serve(0, 1);
        serve(1, 1);
        serve(2, 1);
        tick();
    endtask

    initial begin
        repeat (2) tick();
        chk_idle_outputs("reset");
        chk("reset_cnt", frame_cnt, 8'd0);
        chk("reset_ovr", 8'(overrun), 8'h0);
        chk("reset_tf", 8'(timeout_fault), 8'h0);
        rst = 1'b0;
        tick();
        // nominal
        enable = 1'b1;
        row = 10'd479;
        tick();
        chk("nom_pre_start", 8'(start), 8'h0);
        row = 10'd480;
        tick();
        chk("nom_start0", 8'(start), 8'h1);
        chk("nom_busy", 8'(busy), 8'h1);
        serve(0, 5);
        chk("nom_start1", 8'(start), 8'h2);
        serve(1, 5);
        chk("nom_start2", 8'(start), 8'h4);
        serve(2, 5);
        chk("nom_swap", 8'(swap), 8'h1);
        chk("nom_swap_busy", 8'(busy), 8'h1);
        chk("nom_cnt", frame_cnt, 8'd1);
        tick();
        chk_idle_outputs("nom_after");
        chk("nom_cnt_hold", frame_cnt, 8'd1);
        // timeout on client 1
        vb_enter();
        chk("to_start0", 8'(start), 8'h1);
        serve(0, 2);
        chk("to_start1", 8'(start), 8'h2);
        repeat (19) tick();
        chk("to_not_yet", 8'(start), 8'h0);
        tick();
        chk("to_start2", 8'(start), 8'h4);
        chk("to_fault", 8'(timeout_fault), 8'h2);
        serve(2, 2);
        chk("to_swap", 8'(swap), 8'h1);
        chk("to_cnt", frame_cnt, 8'd2);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("to_clear", 8'(timeout_fault), 8'h0);
        // done[1] colliding with the timeout
        vb_enter();
        serve(0, 2);
        chk("col_start1", 8'(start), 8'h2);
        repeat (19) tick();
        done = 3'b010;
        tick();
        done = 3'b000;
        chk("col_start2", 8'(start), 8'h4);
        chk("col_nofault", 8'(timeout_fault), 8'h0);
        serve(2, 1);
        chk("col_swap", 8'(swap), 8'h1);
        chk("col_cnt", frame_cnt, 8'd3);
        tick();
        // overrun: client 2 silent until vblank ends
        vb_enter();
        serve(0, 1);
        serve(1, 1);
        chk("ovr_start2", 8'(start), 8'h4);
        repeat (3) tick();
        row = 10'd0;
        tick();
        chk("ovr_flag", 8'(overrun), 8'h1);
        chk("ovr_busy", 8'(busy), 8'h0);
        chk("ovr_swap", 8'(swap), 8'h0);
        tick();
        chk("ovr_swap2", 8'(swap), 8'h0);
        chk("ovr_cnt", frame_cnt, 8'd3);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        chk("ovr_clear", 8'(overrun), 8'h0);
        // final done[2] colliding with vb_fall
        vb_enter();
        serve(0, 1);
        serve(1, 1);
        tick();
        row = 10'd0;
        done = 3'b100;
        tick();
        done = 3'b000;
        chk("abort_ovr", 8'(overrun), 8'h1);
        chk("abort_swap", 8'(swap), 8'h0);
        chk("abort_busy", 8'(busy), 8'h0);
        chk("abort_cnt", frame_cnt, 8'd3);
        clr_fault = 1'b1;
        tick();
        clr_fault = 1'b0;
        // foreign done ignored; enable drop mid-sequence does not stop it
        vb_enter();
        chk("mid_start0", 8'(start), 8'h1);
        enable = 1'b0;
        done = 3'b110;
        tick();
        done = 3'b000;
        chk("foreign_start", 8'(start), 8'h0);
        chk("foreign_busy", 8'(busy), 8'h1);
        serve(0, 1);
        chk("mid_start1", 8'(start), 8'h2);
        serve(1, 1);
        serve(2, 1);
        chk("mid_swap", 8'(swap), 8'h1);
        chk("mid_cnt", frame_cnt, 8'd4);
        tick();
        // enable gating
        vb_enter();
        chk_idle_outputs("gate");
        repeat (3) tick();
        chk("gate_busy_later", 8'(busy), 8'h0);
        enable = 1'b1;
        // reset in WAIT1, released mid-vblank
        vb_enter();
        serve(0, 1);
        chk("rst_start1", 8'(start), 8'h2);
        tick();
        rst = 1'b1;
        #1;
        chk_idle_outputs("rst_async");
        chk("rst_cnt", frame_cnt, 8'd0);
        row = 10'd500;
        tick();
        rst = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_nostart", 8'(start), 8'h0);
            chk("rst_nobusy", 8'(busy), 8'h0);
        end
        row = 10'd0;
        tick();
        row = 10'd479;
        tick();
        chk("rst_pre", 8'(start), 8'h0);
        row = 10'd480;
        tick();
        chk("rst_first", 8'(start), 8'h1);
        serve(0, 1);
        serve(1, 1);
        serve(2, 1);
        chk("rst_swap", 8'(swap), 8'h1);
        chk("rst_cnt1", frame_cnt, 8'd1);
        tick();
        // wrap
        repeat (254) clean_frame();
        chk("wrap_255", frame_cnt, 8'd255);
        clean_frame();
        chk("wrap_0", frame_cnt, 8'd0);
        // timeout set while clr_fault held: set wins
        vb_enter();
        chk("clr_start0", 8'(start), 8'h1);
        repeat (18) tick();
        clr_fault = 1'b1;
        tick();
        tick();
        chk("clr_start1", 8'(start), 8'h2);
        chk("clr_set_wins", 8'(timeout_fault), 8'h1);
        clr_fault = 1'b0;
        tick();
        chk("clr_hold", 8'(timeout_fault), 8'h1);
        serve(1, 1);
        serve(2, 1);
        chk("clr_swap", 8'(swap), 8'h1);
        chk("clr_cnt", frame_cnt, 8'd1);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
